cpu_mem_responder: RTL

- Memory-side responder for the CPU's byte-wide bus (address[31:0], read_data[7:0], write_data_mem[7:0], writeBack strobe).
- Provides program/data RAM and a boot loader that fills RAM from a byte stream while holding the CPU in reset.
- Provides a memory-mapped TX FIFO that the CPU drains to an outside byte sink.
- Sits beside cpu at the top level; it drives read_data and the CPU's reset input.

---
 rtl/cpu_mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for the CPU's byte-wide bus.
//   - Program/data RAM, filled by a boot loader while the CPU is held in reset.
//   - Memory-mapped TX FIFO that the CPU fills and an outside sink drains.
// Optional build macro: CPU_MEM_RESP_CYCLE_CNT_EN adds a 32-bit RUN-cycle
// counter, readable bytewise at IO_BASE+4..+7.
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   address             CPU bus address (RAM below MEM_BYTES, I/O at IO_BASE)
//   write_data_mem      CPU store byte, writeBack = store strobe
//   read_data           combinational read byte for the current address
//   cpu_reset           active-high reset for the CPU (held until RUN)
//   load_valid/byte/last, load_ready   boot byte stream
//   tx_valid/data, tx_ready            TX FIFO head towards the byte sink
module cpu_mem_responder #(
  parameter int          MEM_BYTES  = 256,
  parameter int          ADDR_W     = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [7:0]  write_data_mem,
  input  logic        writeBack,
  output logic [7:0]  read_data,
  output logic        cpu_reset,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                load_we;

  logic [7:0]          mem [MEM_BYTES];
  logic [7:0]          fifo [FIFO_DEPTH];
  logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]       cnt_q, cnt_d, free;
  logic                ovf_q, ovf_d;

  logic                is_run, ram_sel, cpu_we;
  logic                empty, full, pop, push, push_ok;
  logic [31:0]         off;

  // ---------------- boot sequencing ----------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    load_we = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (load_valid) begin
          load_we = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          if (load_last || ptr_q == ADDR_W'(MEM_BYTES - 1)) state_d = S_RELEASE;
        end
      end
      // One extra reset cycle so the CPU sees a reset edge after the last byte.
      S_RELEASE: state_d = S_RUN;
      S_RUN:     state_d = S_RUN;
      default:   state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign is_run     = (state_q == S_RUN);
  assign cpu_reset  = !is_run;
  assign load_ready = (state_q == S_LOAD);

  // ---------------- RAM ----------------
  assign ram_sel = (address < 32'(MEM_BYTES));
  assign cpu_we  = is_run && writeBack && ram_sel;

  // Loader and CPU writes are mutually exclusive by state; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_we)     mem[ptr_q]                 <= load_byte;
    else if (cpu_we) mem[address[ADDR_W-1:0]]   <= write_data_mem;
  end

  // ---------------- TX FIFO ----------------
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo[rd_q];
  assign pop      = tx_valid && tx_ready;
  assign push     = is_run && writeBack && (address == IO_BASE);
  // A same-cycle pop frees the slot, so a full FIFO still takes the push.
  assign push_ok  = push && (!full || pop);
  assign free     = CW'(FIFO_DEPTH) - cnt_q;

  always_comb begin
    rd_d  = rd_q + PW'(pop);
    wr_d  = wr_q + PW'(push_ok);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d = ovf_q || (push && !push_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_q] <= write_data_mem;
  end

`ifdef CPU_MEM_RESP_CYCLE_CNT_EN
  // ---------------- RUN-cycle counter ----------------
  logic [31:0] cyc_q, cyc_d;
  always_comb cyc_d = is_run ? cyc_q + 32'd1 : cyc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end
`endif

  // ---------------- read mux ----------------
  assign off = address - IO_BASE;

  always_comb begin
    read_data = 8'h00;
    if (ram_sel)          read_data = mem[address[ADDR_W-1:0]];
    else if (off == 32'd0) read_data = {5'b0, ovf_q, full, empty};
    else if (off == 32'd1) read_data = 8'(free);
`ifdef CPU_MEM_RESP_CYCLE_CNT_EN
    else if (off >= 32'd4 && off <= 32'd7) read_data = cyc_q[8*off[1:0] +: 8];
`endif
  end
endmodule
